// File: rtl/usb_frame_pkg.sv
// Shared frame definitions for the USB RX parser and the future TX framer.
package usb_frame_pkg;

    typedef enum logic [1:0] {ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CKSUM} frame_state_t;

    localparam int MAX_LEN = 255;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic logic [7:0] sum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/frame_stat_cnt.sv
// Saturating statistics counter; holds at all-ones.
module frame_stat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/usb_rx_frame_parser.sv
// Frames the ftdi RX byte stream: SYNC, LEN, payload [, CKSUM when FRAME_CKSUM_EN is defined].
// Emits a registered byte stream with last/err and keeps ok/err frame counters.
//
// state      | meaning
// ST_HUNT    | discard bytes until SYNC_BYTE
// ST_LEN     | next byte is payload length (0 is an error)
// ST_PAYLOAD | forward payload bytes
// ST_CKSUM   | checksum byte expected, final payload byte held (FRAME_CKSUM_EN only)
module usb_rx_frame_parser
    import usb_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 1024,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             out_err,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_err_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int REM_W = $clog2(MAX_LEN + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    frame_state_t     state, state_nxt;
    logic [REM_W-1:0] remaining, remaining_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             out_free, accept, stalled;
    logic             emit, emit_last, emit_err, inc_ok, inc_err;
    logic [7:0]       emit_data;
`ifdef FRAME_CKSUM_EN
    logic [7:0]       sum, sum_nxt, pending, pending_nxt;
`endif

    assign out_free = ~out_valid | out_ready;
    assign stalled  = out_valid & ~out_ready;
    assign in_ready = out_free;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        timer_nxt     = timer;
        emit          = 1'b0;
        emit_data     = in_data;
        emit_last     = 1'b0;
        emit_err      = 1'b0;
        inc_ok        = 1'b0;
        inc_err       = 1'b0;
`ifdef FRAME_CKSUM_EN
        sum_nxt       = sum;
        pending_nxt   = pending;
`endif
        case (state)
            ST_HUNT: begin
                if (accept && (in_data == SYNC_BYTE)) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (accept) begin
                    if (in_data == 8'd0) begin
                        inc_err   = 1'b1;
                        state_nxt = ST_HUNT;
                    end else begin
                        remaining_nxt = REM_W'(in_data);
`ifdef FRAME_CKSUM_EN
                        sum_nxt       = in_data;
`endif
                        state_nxt     = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    remaining_nxt = remaining - REM_W'(1);
`ifdef FRAME_CKSUM_EN
                    sum_nxt = sum_add(sum, in_data);
                    if (remaining == REM_W'(1)) begin
                        pending_nxt = in_data;
                        state_nxt   = ST_CKSUM;
                    end else begin
                        emit = 1'b1;
                    end
`else
                    emit      = 1'b1;
                    emit_last = (remaining == REM_W'(1));
                    if (emit_last) begin
                        inc_ok    = 1'b1;
                        state_nxt = ST_HUNT;
                    end
`endif
                end
            end
`ifdef FRAME_CKSUM_EN
            ST_CKSUM: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_data = pending;
                    emit_last = 1'b1;
                    emit_err  = (sum_add(sum, in_data) != 8'd0);
                    inc_ok    = ~emit_err;
                    inc_err   = emit_err;
                    state_nxt = ST_HUNT;
                end
            end
`endif
            default: state_nxt = ST_HUNT;
        endcase

        // A stalled consumer freezes the timer; an accepted byte always beats a timeout.
        if (state == ST_HUNT || accept) begin
            timer_nxt = '0;
        end else if (!stalled) begin
            if (timer == TMR_LAST) begin
                timer_nxt = '0;
                inc_err   = 1'b1;
                state_nxt = ST_HUNT;
            end else begin
                timer_nxt = timer + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            remaining <= '0;
            timer     <= '0;
`ifdef FRAME_CKSUM_EN
            sum       <= '0;
            pending   <= '0;
`endif
        end else begin
            remaining <= remaining_nxt;
            timer     <= timer_nxt;
`ifdef FRAME_CKSUM_EN
            sum       <= sum_nxt;
            pending   <= pending_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else if (out_free) begin
            out_valid <= emit;
            if (emit) begin
                out_data <= emit_data;
                out_last <= emit_last;
                out_err  <= emit_err;
            end
        end
    end

    frame_stat_cnt #(.W(CNT_W)) u_ok_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (inc_ok),
        .cnt  (frame_ok_cnt)
    );

    frame_stat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (inc_err),
        .cnt  (frame_err_cnt)
    );

endmodule

// File: tb/tb_usb_rx_frame_parser.sv
// Scoreboard bench for usb_rx_frame_parser; expected beats queued as bytes are driven.
module tb_usb_rx_frame_parser;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;
    logic          out_last;
    logic          out_err;
    logic [CW-1:0] frame_ok_cnt;
    logic [CW-1:0] frame_err_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       e;
    } beat_t;

    beat_t exp_q[$];
    beat_t b_exp;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_ok = 0;
    int    exp_err = 0;
    bit    rand_bp = 1'b0;

    usb_rx_frame_parser #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_err       (out_err),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    // Output transfers complete at the following posedge; out_ready only moves at posedge+1.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {22'd0, out_data, out_last, out_err}, 32'hFFFF_FFFF);
            end else begin
                b_exp = exp_q.pop_front();
                chk("beat", {22'd0, out_data, out_last, out_err}, {22'd0, b_exp});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic expect_beat(input logic [7:0] d, input logic l, input logic e);
        exp_q.push_back({d, l, e});
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("in_ready_wait", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 out_ready = r;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", exp_q.size(), 0);
        idle(3);
    endtask

    task automatic check_cnt(input string tag);
        chk({tag, "_ok_cnt"}, 32'(frame_ok_cnt), exp_ok);
        chk({tag, "_err_cnt"}, 32'(frame_err_cnt), exp_err);
    endtask

    initial begin
        idle(3);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last_err", {30'd0, out_last, out_err}, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        check_cnt("rst");
        rstn = 1'b1;
        idle(1);

        // Basic frame
        expect_beat(8'h10, 1'b0, 1'b0);
        expect_beat(8'h11, 1'b0, 1'b0);
        expect_beat(8'h12, 1'b1, 1'b0);
        send(8'hA5); send(8'h03); send(8'h10); send(8'h11); send(8'h12);
        wait_drain();
        exp_ok++;
        check_cnt("basic");

        // Leading garbage is discarded silently
        send(8'h00); send(8'hFF); send(8'h3C);
        expect_beat(8'h77, 1'b1, 1'b0);
        send(8'hA5); send(8'h01); send(8'h77);
        wait_drain();
        exp_ok++;
        check_cnt("garbage");

`ifdef FRAME_CKSUM_EN
        expect_beat(8'h01, 1'b0, 1'b0);
        expect_beat(8'h02, 1'b1, 1'b0);
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'hFB);
        wait_drain();
        exp_ok++;
        check_cnt("cksum_good");
        expect_beat(8'h01, 1'b0, 1'b0);
        expect_beat(8'h02, 1'b1, 1'b1);
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'hFC);
        wait_drain();
        exp_err++;
        check_cnt("cksum_bad");
`else
        // Without checksum the trailing byte is just garbage in HUNT
        expect_beat(8'h01, 1'b0, 1'b0);
        expect_beat(8'h02, 1'b1, 1'b0);
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'hFB);
        wait_drain();
        exp_ok++;
        check_cnt("no_cksum");
`endif

        // Zero length
        send(8'hA5); send(8'h00);
        idle(2);
        exp_err++;
        check_cnt("len0");
        expect_beat(8'h55, 1'b1, 1'b0);
        send(8'hA5); send(8'h01); send(8'h55);
        wait_drain();
        exp_ok++;
        check_cnt("after_len0");

        // Timeout boundary: TO idle cycles after the last accepted byte
        expect_beat(8'h01, 1'b0, 1'b0);
        send(8'hA5); send(8'h04); send(8'h01);
        idle(TO - 1);
        check_cnt("timeout_early");
        idle(1);
        exp_err++;
        check_cnt("timeout");
        idle(4);
        expect_beat(8'h66, 1'b1, 1'b0);
        send(8'hA5); send(8'h01); send(8'h66);
        wait_drain();
        exp_ok++;
        check_cnt("after_timeout");

        // Long consumer stall must not time out
        set_ready(1'b0);
        expect_beat(8'h01, 1'b0, 1'b0);
        expect_beat(8'h02, 1'b0, 1'b0);
        expect_beat(8'h03, 1'b0, 1'b0);
        expect_beat(8'h04, 1'b1, 1'b0);
        fork
            begin
                send(8'hA5); send(8'h04); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
            end
        join_none
        idle(10);
        for (int i = 0; i < 4; i++) begin
            idle(10);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out", {23'd0, out_valid, out_data}, {23'd1, 8'h01});
            check_cnt("stall");
        end
        set_ready(1'b1);
        wait_drain();
        idle(5);
        exp_ok++;
        check_cnt("stall_release");

        // Random frames under random backpressure, sync value used as payload
        rand_bp = 1'b1;
        expect_beat(8'hA5, 1'b0, 1'b0);
        expect_beat(8'hA5, 1'b1, 1'b0);
        send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5);
`ifdef FRAME_CKSUM_EN
        send(8'h100 - 8'(8'h02 + 8'hA5 + 8'hA5));
`endif
        exp_ok++;
        for (int f = 0; f < 6; f++) begin
            int         len;
            logic [7:0] s;
            logic [7:0] b;
            len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) send(8'h3C);
            send(8'hA5);
            send(8'(len));
            s = 8'(len);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                s = s + b;
                expect_beat(b, (i == len - 1), 1'b0);
                send(b);
            end
`ifdef FRAME_CKSUM_EN
            send(8'h00 - s);
`endif
            exp_ok = sat_inc(exp_ok);
        end
        rand_bp = 1'b0;
        set_ready(1'b1);
        wait_drain();
        check_cnt("random");

        // Reset mid-frame discards the held beat and clears counters
        set_ready(1'b0);
        send(8'hA5); send(8'h03); send(8'h10);
        idle(2);
        rstn = 1'b0;
        idle(2);
        chk("midrst_out_valid", 32'(out_valid), 0);
        exp_ok = 0;
        exp_err = 0;
        check_cnt("midrst");
        rstn = 1'b1;
        set_ready(1'b1);
        expect_beat(8'h42, 1'b1, 1'b0);
        send(8'hA5); send(8'h01); send(8'h42);
        wait_drain();
        exp_ok++;
        check_cnt("after_midrst");

        // Error counter saturation
        for (int i = 0; i < (1 << CW) + 1; i++) begin
            send(8'hA5); send(8'h00);
            exp_err = sat_inc(exp_err);
        end
        idle(3);
        check_cnt("saturate");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
